// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-master unified memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } state_e;

    localparam logic MST_CORE = 1'b0;
    localparam logic MST_DMA  = 1'b1;

    // Wide enough for MEM_LATENCY-1 with MEM_LATENCY up to 15.
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of both requester ports, the memory port and arbiter status.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic              m0_done;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic              m1_done;
    logic [DATA_W-1:0] m1_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              grant;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_rdata,
        output m0_ack, m0_done, m0_rdata,
        output m1_ack, m1_done, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy, grant
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_rdata,
        input  m0_ack, m0_done, m0_rdata,
        input  m1_ack, m1_done, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, grant
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the master not served last.
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_served,
    output logic       o_sel,
    output logic       o_valid
);

    always_comb begin
        o_valid = |i_req;
        o_sel   = MST_CORE;
        case (i_req)
            2'b01:   o_sel = MST_CORE;
            2'b10:   o_sel = MST_DMA;
            2'b11:   o_sel = ~i_last_served;
            default: o_sel = MST_CORE;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the core (master 0) and the loader DMA (master 1);
// each accepted access is issued once, waits MEM_LATENCY cycles and ends with a done pulse.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input logic               clock,
    input logic               resetn,
    mem_port_arbiter_if.slave bus
);

    state_e              r_state;
    state_e              w_state_next;
    logic                r_grant;
    logic                r_last_served;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;

    logic                w_sel;
    logic                w_valid;
    logic                w_take;
    logic                w_capture;

    rr_pick2 u_pick (
        .i_req         ({bus.m1_req, bus.m0_req}),
        .i_last_served (r_last_served),
        .o_sel         (w_sel),
        .o_valid       (w_valid)
    );

    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_capture    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_valid) begin
                    w_take       = 1'b1;
                    w_state_next = StIssue;
                end
            end
            StIssue: w_state_next = StWait;
            StWait: begin
                if (r_cnt == '0) begin
                    w_capture    = ~r_mem_we;
                    w_state_next = StResp;
                end
            end
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state       <= StIdle;
            r_grant       <= MST_CORE;
            r_last_served <= MST_DMA;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_cnt         <= '0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_take) begin
                r_grant       <= w_sel;
                r_last_served <= w_sel;
                r_mem_we      <= (w_sel == MST_DMA) ? bus.m1_we    : bus.m0_we;
                r_mem_addr    <= (w_sel == MST_DMA) ? bus.m1_addr  : bus.m0_addr;
                r_mem_wdata   <= (w_sel == MST_DMA) ? bus.m1_wdata : bus.m0_wdata;
            end
            // Counter reaches 0 on the WAIT cycle where mem_rdata is valid.
            if (r_state == StIssue) begin
                r_cnt <= CNT_W'(MEM_LATENCY - 1);
            end else if ((r_state == StWait) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_capture) begin
                if (r_grant == MST_DMA) begin
                    r_rdata1 <= bus.mem_rdata;
                end else begin
                    r_rdata0 <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.m0_ack    = w_take && (w_sel == MST_CORE);
    assign bus.m1_ack    = w_take && (w_sel == MST_DMA);
    assign bus.m0_done   = (r_state == StResp) && (r_grant == MST_CORE);
    assign bus.m1_done   = (r_state == StResp) && (r_grant == MST_DMA);
    assign bus.m0_rdata  = r_rdata0;
    assign bus.m1_rdata  = r_rdata1;
    assign bus.mem_en    = (r_state == StIssue);
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = (r_state != StIdle);
    assign bus.grant     = r_grant;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: DUT A uses MEM_LATENCY=1, DUT B uses MEM_LATENCY=3.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef struct { int cyc; logic mst; } ack_t;
    typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; } iss_t;
    typedef struct { int cyc; logic mst; logic [31:0] rdata; logic [31:0] other; } done_t;

    ack_t  q_ack  [2][$];
    iss_t  q_iss  [2][$];
    done_t q_done [2][$];
    logic [31:0] exp_rd [2][2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic clock  = 1'b0;
    logic rstn_a = 1'b0;
    logic rstn_b = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)) dut_a (
        .clock  (clock),
        .resetn (rstn_a),
        .bus    (bus_a)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(3)) dut_b (
        .clock  (clock),
        .resetn (rstn_b),
        .bus    (bus_b)
    );

    function automatic logic [31:0] init_word(input logic [7:0] a);
        case (a)
            8'h10:   return 32'hDEAD_BEEF;
            8'h30:   return 32'h1234_5678;
            default: return {24'hA5A5A5, a};
        endcase
    endfunction

    // Memory models: read data is valid only exactly MEM_LATENCY cycles after mem_en.
    logic [31:0]  mem_a [256];
    logic [255:0] wr_a = '0;
    logic         pa_en;
    logic [7:0]   pa_addr;
    always @(posedge clock) begin
        pa_en   <= bus_a.mem_en;
        pa_addr <= bus_a.mem_addr[7:0];
        if (bus_a.mem_en && bus_a.mem_we) begin
            mem_a[bus_a.mem_addr[7:0]] <= bus_a.mem_wdata;
            wr_a[bus_a.mem_addr[7:0]]  <= 1'b1;
        end
    end
    assign bus_a.mem_rdata = !pa_en ? 32'hBAD0_BAD0 :
                             (wr_a[pa_addr] ? mem_a[pa_addr] : init_word(pa_addr));

    logic [2:0] pb_en;
    logic [7:0] pb_addr [3];
    always @(posedge clock) begin
        pb_en      <= {pb_en[1:0], bus_b.mem_en};
        pb_addr[0] <= bus_b.mem_addr[7:0];
        pb_addr[1] <= pb_addr[0];
        pb_addr[2] <= pb_addr[1];
    end
    assign bus_b.mem_rdata = pb_en[2] ? init_word(pb_addr[2]) : 32'hBAD0_BAD0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pushes the expected ack, issue and (unless aborted) done of one access.
    task automatic exp_txn(input int d, input logic mst, input int ta, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] new_rd, input int lat, input bit abort);
        ack_t  a;
        iss_t  i;
        done_t n;
        a.cyc = ta; a.mst = mst;
        q_ack[d].push_back(a);
        i.cyc = ta + 1; i.we = we; i.addr = addr; i.wdata = wdata;
        q_iss[d].push_back(i);
        if (!abort) begin
            if (!we) exp_rd[d][mst] = new_rd;
            n.cyc = ta + 2 + lat; n.mst = mst;
            n.rdata = exp_rd[d][mst]; n.other = exp_rd[d][~mst];
            q_done[d].push_back(n);
        end
    endtask

    task automatic monitor(input int d, input logic a0, input logic a1, input logic bsy,
                           input logic en, input logic we, input logic dn0, input logic dn1,
                           input logic gnt, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rd0, input logic [31:0] rd1);
        ack_t  a;
        iss_t  i;
        done_t n;
        if (a0 || a1) begin
            check("ack_only_in_idle", 32'(bsy), 32'(0));
            if (q_ack[d].size() == 0) begin
                check("ack_unexpected", 32'({a1, a0}), 32'(0));
            end else begin
                a = q_ack[d].pop_front();
                check("ack_cycle", cyc, a.cyc);
                check("ack_master", 32'({a1, a0}), a.mst ? 32'd2 : 32'd1);
            end
        end
        if (en) begin
            if (q_iss[d].size() == 0) begin
                check("mem_en_unexpected", 32'(en), 32'(0));
            end else begin
                i = q_iss[d].pop_front();
                check("mem_en_cycle", cyc, i.cyc);
                check("mem_we", 32'(we), 32'(i.we));
                check("mem_addr", addr, i.addr);
                if (i.we) check("mem_wdata", wdata, i.wdata);
            end
        end
        if (dn0 || dn1) begin
            if (q_done[d].size() == 0) begin
                check("done_unexpected", 32'({dn1, dn0}), 32'(0));
            end else begin
                n = q_done[d].pop_front();
                check("done_cycle", cyc, n.cyc);
                check("done_master", 32'({dn1, dn0}), n.mst ? 32'd2 : 32'd1);
                check("grant", 32'(gnt), 32'(n.mst));
                check("rdata_granted", n.mst ? rd1 : rd0, n.rdata);
                check("rdata_other", n.mst ? rd0 : rd1, n.other);
            end
        end
    endtask

    always @(negedge clock) begin
        if (rstn_a) monitor(0, bus_a.m0_ack, bus_a.m1_ack, bus_a.busy, bus_a.mem_en, bus_a.mem_we,
                            bus_a.m0_done, bus_a.m1_done, bus_a.grant, bus_a.mem_addr,
                            bus_a.mem_wdata, bus_a.m0_rdata, bus_a.m1_rdata);
        if (rstn_b) monitor(1, bus_b.m0_ack, bus_b.m1_ack, bus_b.busy, bus_b.mem_en, bus_b.mem_we,
                            bus_b.m0_done, bus_b.m1_done, bus_b.grant, bus_b.mem_addr,
                            bus_b.mem_wdata, bus_b.m0_rdata, bus_b.m1_rdata);
    end

    initial begin
        int t;
        bus_a.m0_req = 0; bus_a.m0_we = 0; bus_a.m0_addr = '0; bus_a.m0_wdata = '0;
        bus_a.m1_req = 0; bus_a.m1_we = 0; bus_a.m1_addr = '0; bus_a.m1_wdata = '0;
        bus_b.m0_req = 0; bus_b.m0_we = 0; bus_b.m0_addr = '0; bus_b.m0_wdata = '0;
        bus_b.m1_req = 0; bus_b.m1_we = 0; bus_b.m1_addr = '0; bus_b.m1_wdata = '0;
        for (int d = 0; d < 2; d++) begin
            exp_rd[d][0] = '0;
            exp_rd[d][1] = '0;
        end
        repeat (3) tick();

        check("rst_ctrl", 32'({bus_a.busy, bus_a.grant, bus_a.mem_en, bus_a.mem_we}), 32'(0));
        check("rst_mem_addr", bus_a.mem_addr, 32'h0);
        check("rst_mem_wdata", bus_a.mem_wdata, 32'h0);
        check("rst_done", 32'({bus_a.m0_done, bus_a.m1_done}), 32'(0));
        check("rst_rdata0", bus_a.m0_rdata, 32'h0);
        check("rst_rdata1", bus_a.m1_rdata, 32'h0);
        check("rst_b_busy", 32'(bus_b.busy), 32'(0));

        // Tie straight out of reset: master 0 first, master 1 next.
        rstn_a = 1; rstn_b = 1; t = cyc;
        bus_a.m0_req = 1; bus_a.m0_addr = 32'h14;
        bus_a.m1_req = 1; bus_a.m1_addr = 32'h30;
        exp_txn(0, 0, t,     0, 32'h14, 0, 32'hA5A5_A514, 1, 0);
        exp_txn(0, 1, t + 4, 0, 32'h30, 0, 32'h1234_5678, 1, 0);
        tick(); bus_a.m0_req = 0;
        repeat (4) tick(); bus_a.m1_req = 0;
        repeat (4) tick();

        // Single master 0 read.
        t = cyc; bus_a.m0_req = 1; bus_a.m0_addr = 32'h10;
        exp_txn(0, 0, t, 0, 32'h10, 0, 32'hDEAD_BEEF, 1, 0);
        tick(); bus_a.m0_req = 0;
        repeat (4) tick();

        // Master 1 write, then read it back.
        t = cyc; bus_a.m1_req = 1; bus_a.m1_we = 1; bus_a.m1_addr = 32'h20;
        bus_a.m1_wdata = 32'h55;
        exp_txn(0, 1, t, 1, 32'h20, 32'h55, 0, 1, 0);
        tick(); bus_a.m1_req = 0; bus_a.m1_we = 0; bus_a.m1_wdata = '0;
        repeat (3) tick();
        t = cyc; bus_a.m1_req = 1;
        exp_txn(0, 1, t, 0, 32'h20, 0, 32'h55, 1, 0);
        tick(); bus_a.m1_req = 0;
        repeat (4) tick();

        // Continuous dual requests: grants alternate 0,1,0,1,0,1.
        t = cyc;
        bus_a.m0_req = 1; bus_a.m0_addr = 32'h18;
        bus_a.m1_req = 1; bus_a.m1_addr = 32'h30;
        for (int k = 0; k < 6; k++) begin
            exp_txn(0, k[0], t + 4 * k, 0, k[0] ? 32'h30 : 32'h18, 0,
                    k[0] ? 32'h1234_5678 : 32'hA5A5_A518, 1, 0);
        end
        repeat (21) tick();
        bus_a.m0_req = 0; bus_a.m1_req = 0;
        repeat (5) tick();

        // Reset while in WAIT: access aborted, no done.
        t = cyc; bus_a.m0_req = 1; bus_a.m0_addr = 32'h10;
        exp_txn(0, 0, t, 0, 32'h10, 0, 0, 1, 1);
        tick(); bus_a.m0_req = 0;
        tick(); rstn_a = 0;
        tick(); rstn_a = 1;
        check("mid_rst_busy", 32'(bus_a.busy), 32'(0));
        check("mid_rst_mem_en", 32'(bus_a.mem_en), 32'(0));
        check("mid_rst_done", 32'(bus_a.m0_done), 32'(0));
        check("mid_rst_rdata0", bus_a.m0_rdata, 32'h0);
        exp_rd[0][0] = '0; exp_rd[0][1] = '0;
        repeat (2) tick();
        t = cyc; bus_a.m0_req = 1;
        exp_txn(0, 0, t, 0, 32'h10, 0, 32'hDEAD_BEEF, 1, 0);
        tick(); bus_a.m0_req = 0;
        repeat (5) tick();

        // MEM_LATENCY=3 read: busy spans cycles 1..5 of the access.
        t = cyc; bus_b.m0_req = 1; bus_b.m0_addr = 32'h40;
        exp_txn(1, 0, t, 0, 32'h40, 0, 32'hA5A5_A540, 3, 0);
        for (int k = 0; k <= 6; k++) begin
            check("lat3_busy", 32'(bus_b.busy), 32'((k >= 1) && (k <= 5)));
            tick();
            if (k == 0) bus_b.m0_req = 0;
        end
        repeat (3) tick();

        for (int d = 0; d < 2; d++) begin
            check("pending_acks", q_ack[d].size(), 0);
            check("pending_issues", q_iss[d].size(), 0);
            check("pending_dones", q_done[d].size(), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
